// File: rtl/lpif_asym_pkg.sv
// Shared definitions for the LPIF asymmetric gearbox: beat layout, field
// offsets, width helpers and the legal-ratio check.
package lpif_asym_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CRC_W  = 4;

  localparam int STATE_W  = 4;
  localparam int PROTID_W = 2;

  // Fixed-position fields, LSB first.
  localparam int OFF_STATE  = 0;
  localparam int OFF_PROTID = OFF_STATE + STATE_W;
  localparam int OFF_DATA   = OFF_PROTID + PROTID_W;

  // Fields after the data payload move with DATA_W / CRC_W.
  function automatic int off_dvalid(input int data_w);
    return OFF_DATA + data_w;
  endfunction

  function automatic int off_crc(input int data_w);
    return off_dvalid(data_w) + 1;
  endfunction

  function automatic int off_crc_valid(input int data_w, input int crc_w);
    return off_crc(data_w) + crc_w;
  endfunction

  function automatic int off_valid(input int data_w, input int crc_w);
    return off_crc_valid(data_w, crc_w) + 1;
  endfunction

  function automatic int beat_w(input int data_w, input int crc_w);
    return data_w + crc_w + 9;
  endfunction

  function automatic bit ratio_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4);
  endfunction

  // Beats per word when the gen2 mode pin is low.
  function automatic int reff_lo(input int ratio);
    return (ratio / 2 > 1) ? ratio / 2 : 1;
  endfunction

  function automatic int cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Reference beat at default widths; packed MSB-first, so the last member
  // (state) lands at bit 0.
  typedef struct packed {
    logic                  valid;
    logic                  crc_valid;
    logic [DEF_CRC_W-1:0]  crc;
    logic                  dvalid;
    logic [DEF_DATA_W-1:0] data;
    logic [PROTID_W-1:0]   protid;
    logic [STATE_W-1:0]    state;
  } lpif_beat_t;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_STREAM = 1'b1
  } rx_state_e;

endpackage

// File: rtl/lpif_asym_gearbox_lane.sv
// One gearbox lane. Pack mode gathers R_eff beats into a word held until the
// sink takes it; unpack mode splits a captured word into one registered beat
// per cycle. last_i is R_eff-1 and must only change while the lane is idle.
module lpif_asym_gearbox_lane
  import lpif_asym_pkg::*;
#(
  parameter int  BEAT_W = 77,
  parameter int  RATIO  = 2,
  parameter bit  UNPACK = 1'b0,
  localparam int CNT_W  = cnt_w(RATIO),
  localparam int WORD_W = RATIO * BEAT_W,
  localparam int IN_W   = UNPACK ? WORD_W : BEAT_W,
  localparam int OUT_W  = UNPACK ? BEAT_W : WORD_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  if (!UNPACK) begin : g_pack
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              accept;

    // A new beat may enter the same cycle the pending word drains.
    assign in_ready_o = en_i & (~valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    // Next-state: drop valid on drain, write the accepted beat into its slot.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = valid_q;
      if (valid_q && out_ready_i) valid_d = 1'b0;
      if (accept) begin
        // Starting a word clears every slot, so slots at R_eff and above stay zero.
        if (cnt_q == '0) word_d = '0;
        word_d[cnt_q*BEAT_W +: BEAT_W] = in_data_i;
        if (cnt_q == last_i) begin
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Slot counter, word register and valid flag.
    always_ff @(posedge clk_i) begin
      // NOTE: the word register is reset too, so no partial word survives a reset.
      if (rst_i) begin
        cnt_q   <= '0;
        word_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments only.
        cnt_q   <= cnt_d;
        word_q  <= word_d;
        valid_q <= valid_d;
      end
    end

    assign out_data_o  = word_q;
    assign out_valid_o = valid_q;
    assign busy_o      = valid_q | (cnt_q != '0);

  end else begin : g_unpack
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              capture;
    logic              unused_ok;

    // The downstream side never stalls.
    assign unused_ok = out_ready_i;

    // Take a new word when idle or while the last beat of the current one is out.
    assign in_ready_o = en_i & ((state_q == RX_IDLE) | (cnt_q == last_i));
    assign capture    = in_valid_i & in_ready_o;

    // Next-state: slot 0 of a captured word goes out next cycle, then the rest in order.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      beat_d  = beat_q;
      if (capture) begin
        state_d = RX_STREAM;
        cnt_d   = '0;
        word_d  = in_data_i;
        beat_d  = in_data_i[0 +: BEAT_W];
      end else if ((state_q == RX_STREAM) && (cnt_q != last_i)) begin
        cnt_d  = cnt_q + 1'b1;
        beat_d = word_q[cnt_d*BEAT_W +: BEAT_W];
      end else begin
        state_d = RX_IDLE;
        cnt_d   = '0;
        beat_d  = '0;
      end
    end

    // State, slot counter, captured word and output beat register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= RX_IDLE;
        cnt_q   <= '0;
        word_q  <= '0;
        beat_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        word_q  <= word_d;
        beat_q  <= beat_d;
      end
    end

    assign out_data_o  = beat_q;
    assign out_valid_o = (state_q == RX_STREAM);
    assign busy_o      = (state_q == RX_STREAM);
  end

endmodule

// File: rtl/lpif_txrx_asym_gearbox_slave_name.sv
// LPIF TX/RX asymmetric gearbox: packs upstream beats into TX FIFO words and
// unpacks RX FIFO words into downstream beats, R_eff beats per word.
module lpif_txrx_asym_gearbox_slave_name
  import lpif_asym_pkg::*;
#(
  parameter int  DATA_W = 64,
  parameter int  CRC_W  = 4,
  parameter int  RATIO  = 2,
  localparam int BEAT_W = beat_w(DATA_W, CRC_W),
  localparam int WORD_W = RATIO * BEAT_W
) (
  input  logic              clk_wr,
  input  logic              rst_wr,
  input  logic              m_gen2_mode,
  input  logic [3:0]        ustrm_state,
  input  logic [1:0]        ustrm_protid,
  input  logic [DATA_W-1:0] ustrm_data,
  input  logic              ustrm_dvalid,
  input  logic [CRC_W-1:0]  ustrm_crc,
  input  logic              ustrm_crc_valid,
  input  logic              ustrm_valid,
  output logic              ustrm_ready,
  output logic [WORD_W-1:0] txfifo_upstream_data,
  output logic              txfifo_upstream_valid,
  input  logic              txfifo_upstream_ready,
  input  logic [WORD_W-1:0] rxfifo_downstream_data,
  input  logic              rxfifo_downstream_valid,
  output logic              rxfifo_downstream_ready,
  output logic [3:0]        dstrm_state,
  output logic [1:0]        dstrm_protid,
  output logic [DATA_W-1:0] dstrm_data,
  output logic              dstrm_dvalid,
  output logic [CRC_W-1:0]  dstrm_crc,
  output logic              dstrm_crc_valid,
  output logic              dstrm_valid,
  output logic              mode_busy
);

  if (!ratio_legal(RATIO)) begin : g_bad_ratio
    $error("lpif_txrx_asym_gearbox_slave_name: RATIO must be 1, 2 or 4");
  end

  if ((DATA_W == DEF_DATA_W) && (CRC_W == DEF_CRC_W) &&
      ($bits(lpif_beat_t) != BEAT_W)) begin : g_bad_layout
    $error("lpif_txrx_asym_gearbox_slave_name: beat struct and offsets disagree");
  end

  localparam int               CNT_W   = cnt_w(RATIO);
  localparam logic [CNT_W-1:0] LAST_HI = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] LAST_LO = CNT_W'(reff_lo(RATIO) - 1);
  localparam int               OFF_DV  = off_dvalid(DATA_W);
  localparam int               OFF_CRC = off_crc(DATA_W);
  localparam int               OFF_CV  = off_crc_valid(DATA_W, CRC_W);
  localparam int               OFF_V   = off_valid(DATA_W, CRC_W);

  logic              gen2_q;
  logic              en_q;
  logic              tx_busy;
  logic              rx_busy;
  logic [CNT_W-1:0]  last_idx;
  logic [BEAT_W-1:0] ustrm_beat;
  logic [BEAT_W-1:0] rx_beat;
  logic              rx_beat_valid;

  assign mode_busy = tx_busy | rx_busy;

  // While idle the live pin decides, so a word that starts in the cycle the
  // register reloads is built with the same R_eff it will finish with.
  assign last_idx = (mode_busy ? gen2_q : m_gen2_mode) ? LAST_HI : LAST_LO;

  // Mode register (reloads only when idle) and post-reset ready enable.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      gen2_q <= m_gen2_mode;
      en_q   <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (!mode_busy) gen2_q <= m_gen2_mode;
    end
  end

  // Assemble the upstream beat in the shared slot layout.
  always_comb begin
    ustrm_beat                          = '0;
    ustrm_beat[OFF_STATE +: STATE_W]    = ustrm_state;
    ustrm_beat[OFF_PROTID +: PROTID_W]  = ustrm_protid;
    ustrm_beat[OFF_DATA +: DATA_W]      = ustrm_data;
    ustrm_beat[OFF_DV]                  = ustrm_dvalid;
    ustrm_beat[OFF_CRC +: CRC_W]        = ustrm_crc;
    ustrm_beat[OFF_CV]                  = ustrm_crc_valid;
    ustrm_beat[OFF_V]                   = ustrm_valid;
  end

  lpif_asym_gearbox_lane #(
    .BEAT_W (BEAT_W),
    .RATIO  (RATIO),
    .UNPACK (1'b0)
  ) u_tx_lane (
    .clk_i       (clk_wr),
    .rst_i       (rst_wr),
    .en_i        (en_q),
    .last_i      (last_idx),
    .in_data_i   (ustrm_beat),
    .in_valid_i  (ustrm_valid),
    .in_ready_o  (ustrm_ready),
    .out_data_o  (txfifo_upstream_data),
    .out_valid_o (txfifo_upstream_valid),
    .out_ready_i (txfifo_upstream_ready),
    .busy_o      (tx_busy)
  );

  lpif_asym_gearbox_lane #(
    .BEAT_W (BEAT_W),
    .RATIO  (RATIO),
    .UNPACK (1'b1)
  ) u_rx_lane (
    .clk_i       (clk_wr),
    .rst_i       (rst_wr),
    .en_i        (en_q),
    .last_i      (last_idx),
    .in_data_i   (rxfifo_downstream_data),
    .in_valid_i  (rxfifo_downstream_valid),
    .in_ready_o  (rxfifo_downstream_ready),
    .out_data_o  (rx_beat),
    .out_valid_o (rx_beat_valid),
    .out_ready_i (1'b1),
    .busy_o      (rx_busy)
  );

  // The beat register is already zero when nothing is being emitted.
  assign dstrm_state     = rx_beat[OFF_STATE +: STATE_W];
  assign dstrm_protid    = rx_beat[OFF_PROTID +: PROTID_W];
  assign dstrm_data      = rx_beat[OFF_DATA +: DATA_W];
  assign dstrm_dvalid    = rx_beat[OFF_DV];
  assign dstrm_crc       = rx_beat[OFF_CRC +: CRC_W];
  assign dstrm_crc_valid = rx_beat[OFF_CV];
  assign dstrm_valid     = rx_beat[OFF_V] & rx_beat_valid;

endmodule

// File: tb/tb_lpif_txrx_asym_gearbox_slave_name.sv
// Directed bench for the LPIF asymmetric gearbox at RATIO 1, 2 and 4. All
// three instances share their inputs; each scenario checks one of them.
module tb_lpif_txrx_asym_gearbox_slave_name;

  logic         clk = 1'b0;
  logic         rst;
  logic         gen2;
  logic [3:0]   u_state;
  logic [1:0]   u_protid;
  logic [63:0]  u_data;
  logic         u_dvalid;
  logic [3:0]   u_crc;
  logic         u_crc_valid;
  logic         u_valid;
  logic         tx_rdy;
  logic [307:0] rx_word;
  logic         rx_valid;

  logic         ur_1, txv_1, rxr_1, busy_1;
  logic         ur_2, txv_2, rxr_2, busy_2;
  logic         ur_4, txv_4, rxr_4, busy_4;
  logic [76:0]  txd_1;
  logic [153:0] txd_2;
  logic [307:0] txd_4;
  logic [76:0]  db_1, db_2, db_4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lpif_txrx_asym_gearbox_slave_name #(.RATIO(1)) u_r1 (
    .clk_wr(clk), .rst_wr(rst), .m_gen2_mode(gen2),
    .ustrm_state(u_state), .ustrm_protid(u_protid), .ustrm_data(u_data),
    .ustrm_dvalid(u_dvalid), .ustrm_crc(u_crc), .ustrm_crc_valid(u_crc_valid),
    .ustrm_valid(u_valid), .ustrm_ready(ur_1),
    .txfifo_upstream_data(txd_1), .txfifo_upstream_valid(txv_1), .txfifo_upstream_ready(tx_rdy),
    .rxfifo_downstream_data(rx_word[76:0]), .rxfifo_downstream_valid(rx_valid),
    .rxfifo_downstream_ready(rxr_1),
    .dstrm_state(db_1[3:0]), .dstrm_protid(db_1[5:4]), .dstrm_data(db_1[69:6]),
    .dstrm_dvalid(db_1[70]), .dstrm_crc(db_1[74:71]), .dstrm_crc_valid(db_1[75]),
    .dstrm_valid(db_1[76]), .mode_busy(busy_1)
  );

  lpif_txrx_asym_gearbox_slave_name #(.RATIO(2)) u_r2 (
    .clk_wr(clk), .rst_wr(rst), .m_gen2_mode(gen2),
    .ustrm_state(u_state), .ustrm_protid(u_protid), .ustrm_data(u_data),
    .ustrm_dvalid(u_dvalid), .ustrm_crc(u_crc), .ustrm_crc_valid(u_crc_valid),
    .ustrm_valid(u_valid), .ustrm_ready(ur_2),
    .txfifo_upstream_data(txd_2), .txfifo_upstream_valid(txv_2), .txfifo_upstream_ready(tx_rdy),
    .rxfifo_downstream_data(rx_word[153:0]), .rxfifo_downstream_valid(rx_valid),
    .rxfifo_downstream_ready(rxr_2),
    .dstrm_state(db_2[3:0]), .dstrm_protid(db_2[5:4]), .dstrm_data(db_2[69:6]),
    .dstrm_dvalid(db_2[70]), .dstrm_crc(db_2[74:71]), .dstrm_crc_valid(db_2[75]),
    .dstrm_valid(db_2[76]), .mode_busy(busy_2)
  );

  lpif_txrx_asym_gearbox_slave_name #(.RATIO(4)) u_r4 (
    .clk_wr(clk), .rst_wr(rst), .m_gen2_mode(gen2),
    .ustrm_state(u_state), .ustrm_protid(u_protid), .ustrm_data(u_data),
    .ustrm_dvalid(u_dvalid), .ustrm_crc(u_crc), .ustrm_crc_valid(u_crc_valid),
    .ustrm_valid(u_valid), .ustrm_ready(ur_4),
    .txfifo_upstream_data(txd_4), .txfifo_upstream_valid(txv_4), .txfifo_upstream_ready(tx_rdy),
    .rxfifo_downstream_data(rx_word), .rxfifo_downstream_valid(rx_valid),
    .rxfifo_downstream_ready(rxr_4),
    .dstrm_state(db_4[3:0]), .dstrm_protid(db_4[5:4]), .dstrm_data(db_4[69:6]),
    .dstrm_dvalid(db_4[70]), .dstrm_crc(db_4[74:71]), .dstrm_crc_valid(db_4[75]),
    .dstrm_valid(db_4[76]), .mode_busy(busy_4)
  );

  // Expected 77-bit slot for tag n, written out field by field, MSB first:
  // valid, crc_valid, crc, dvalid, data, protid, state.
  function automatic logic [76:0] mk(input logic [7:0] n);
    return {1'b1, 1'b1, ~n[3:0], n[0], {8{n}}, n[5:4], n[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [7:0] n);
    u_valid     = 1'b1;
    u_state     = n[3:0];
    u_protid    = n[5:4];
    u_data      = {8{n}};
    u_dvalid    = n[0];
    u_crc       = ~n[3:0];
    u_crc_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    u_valid = 1'b0; u_state = '0; u_protid = '0; u_data = '0;
    u_dvalid = 1'b0; u_crc = '0; u_crc_valid = 1'b0;
    rx_valid = 1'b0; rx_word = '0; tx_rdy = 1'b1;
  endtask

  task automatic do_reset(input logic g);
    rst = 1'b1; gen2 = g; idle_inputs();
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; gen2 = 1'b1; idle_inputs();
    step(); step(); settle();
    n_total++;
    if ({txv_2, ur_2, rxr_2, busy_2, db_2} !== 81'd0)
      $display("FAIL reset_outputs: got %h expected 0", {txv_2, ur_2, rxr_2, busy_2, db_2});
    else n_pass++;
    n_total++;
    if ({txv_4, ur_4, rxr_4, busy_4, db_4} !== 81'd0)
      $display("FAIL reset_outputs_r4: got %h expected 0", {txv_4, ur_4, rxr_4, busy_4, db_4});
    else n_pass++;
    rst = 1'b0;
    step(); settle();
    n_total++;
    if ({ur_2, rxr_2} !== 2'b11)
      $display("FAIL reset_release_ready: got %b expected 11", {ur_2, rxr_2});
    else n_pass++;
  endtask

  task automatic test_pack_r2_gen2();
    do_reset(1'b1);
    drive(8'd1); settle();
    n_total++;
    if (txv_2 !== 1'b0) $display("FAIL pack2_idle_valid: got %b expected 0", txv_2);
    else n_pass++;
    step(); drive(8'd2); settle();
    n_total++;
    if (txv_2 !== 1'b0) $display("FAIL pack2_partial_valid: got %b expected 0", txv_2);
    else n_pass++;
    step(); drive(8'd3); settle();
    n_total++;
    if ({txv_2, txd_2} !== {1'b1, mk(8'd2), mk(8'd1)})
      $display("FAIL pack2_word0: got %h expected %h", {txv_2, txd_2}, {1'b1, mk(8'd2), mk(8'd1)});
    else n_pass++;
    step(); drive(8'd4); settle();
    n_total++;
    if (txv_2 !== 1'b0) $display("FAIL pack2_gap_valid: got %b expected 0", txv_2);
    else n_pass++;
    step(); u_valid = 1'b0; settle();
    n_total++;
    if ({txv_2, txd_2} !== {1'b1, mk(8'd4), mk(8'd3)})
      $display("FAIL pack2_word1: got %h expected %h", {txv_2, txd_2}, {1'b1, mk(8'd4), mk(8'd3)});
    else n_pass++;
    step(); settle();
    n_total++;
    if (txv_2 !== 1'b0) $display("FAIL pack2_drained: got %b expected 0", txv_2);
    else n_pass++;
  endtask

  task automatic test_single_beat_r2();
    logic [76:0] exp_beat [3];
    do_reset(1'b0);
    drive(8'hA5);
    step(); u_valid = 1'b0; settle();
    n_total++;
    if ({txv_2, txd_2} !== {1'b1, 77'd0, mk(8'hA5)})
      $display("FAIL single_word: got %h expected %h", {txv_2, txd_2}, {1'b1, 77'd0, mk(8'hA5)});
    else n_pass++;
    exp_beat[0] = mk(8'h10); exp_beat[1] = mk(8'h11); exp_beat[2] = mk(8'h12);
    rx_valid = 1'b1;
    rx_word  = {154'd0, mk(8'h99), exp_beat[0]};
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) rx_word = {154'd0, mk(8'h99), exp_beat[i+1]};
      else rx_valid = 1'b0;
      settle();
      n_total++;
      if (db_2 !== exp_beat[i])
        $display("FAIL single_rx_beat%0d: got %h expected %h", i, db_2, exp_beat[i]);
      else n_pass++;
    end
    step(); settle();
    n_total++;
    if (db_2 !== 77'd0) $display("FAIL single_rx_idle: got %h expected 0", db_2);
    else n_pass++;
  endtask

  task automatic test_stall_r4();
    logic [307:0] exp_word;
    do_reset(1'b1);
    tx_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(8'(i));
      step();
    end
    drive(8'd5);
    exp_word = {mk(8'd4), mk(8'd3), mk(8'd2), mk(8'd1)};
    for (int i = 0; i < 5; i++) begin
      settle();
      n_total++;
      if ({txv_4, ur_4, txd_4} !== {1'b1, 1'b0, exp_word})
        $display("FAIL stall_hold%0d: got %h expected %h", i, {txv_4, ur_4, txd_4}, {1'b1, 1'b0, exp_word});
      else n_pass++;
      step();
    end
    tx_rdy = 1'b1; settle();
    n_total++;
    if (ur_4 !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", ur_4);
    else n_pass++;
    for (int i = 6; i <= 8; i++) begin
      step();
      drive(8'(i));
    end
    step(); u_valid = 1'b0; settle();
    exp_word = {mk(8'd8), mk(8'd7), mk(8'd6), mk(8'd5)};
    n_total++;
    if ({txv_4, txd_4} !== {1'b1, exp_word})
      $display("FAIL stall_next_word: got %h expected %h", {txv_4, txd_4}, {1'b1, exp_word});
    else n_pass++;
  endtask

  task automatic test_back_to_back_rx_r2();
    logic [77:0] exp_tbl [5];
    do_reset(1'b1);
    rx_valid = 1'b1;
    rx_word  = {154'd0, mk(8'h21), mk(8'h20)};
    // {rxfifo_downstream_ready, dstrm beat} per cycle after the first capture.
    exp_tbl[0] = {1'b0, mk(8'h20)};
    exp_tbl[1] = {1'b1, mk(8'h21)};
    exp_tbl[2] = {1'b0, mk(8'h22)};
    exp_tbl[3] = {1'b1, mk(8'h23)};
    exp_tbl[4] = {1'b1, 77'd0};
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) rx_word = {154'd0, mk(8'h23), mk(8'h22)};
      if (i == 1) rx_valid = 1'b1;
      if (i == 2) rx_valid = 1'b0;
      settle();
      n_total++;
      if ({rxr_2, db_2} !== exp_tbl[i])
        $display("FAIL b2b_rx%0d: got %h expected %h", i, {rxr_2, db_2}, exp_tbl[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mode_switch_r2();
    do_reset(1'b1);
    drive(8'h31);
    step(); gen2 = 1'b0; drive(8'h32); settle();
    n_total++;
    if (busy_2 !== 1'b1) $display("FAIL mode_busy_partial: got %b expected 1", busy_2);
    else n_pass++;
    step(); u_valid = 1'b0; settle();
    n_total++;
    if ({txv_2, txd_2} !== {1'b1, mk(8'h32), mk(8'h31)})
      $display("FAIL mode_old_word: got %h expected %h", {txv_2, txd_2}, {1'b1, mk(8'h32), mk(8'h31)});
    else n_pass++;
    step(); step();
    drive(8'h33);
    step(); u_valid = 1'b0; settle();
    n_total++;
    if ({txv_2, txd_2} !== {1'b1, 77'd0, mk(8'h33)})
      $display("FAIL mode_new_word: got %h expected %h", {txv_2, txd_2}, {1'b1, 77'd0, mk(8'h33)});
    else n_pass++;
  endtask

  task automatic test_reset_mid_r2();
    do_reset(1'b1);
    drive(8'h41);
    rx_word  = {154'd0, mk(8'h51), mk(8'h50)};
    rx_valid = 1'b1;
    step(); u_valid = 1'b0; rx_valid = 1'b0; settle();
    n_total++;
    if (db_2 !== mk(8'h50)) $display("FAIL midrst_stream_start: got %h expected %h", db_2, mk(8'h50));
    else n_pass++;
    rst = 1'b1;
    step(); settle();
    n_total++;
    if ({txv_2, ur_2, rxr_2, busy_2, db_2} !== 81'd0)
      $display("FAIL midrst_during: got %h expected 0", {txv_2, ur_2, rxr_2, busy_2, db_2});
    else n_pass++;
    rst = 1'b0;
    step(); settle();
    n_total++;
    if ({ur_2, rxr_2} !== 2'b11) $display("FAIL midrst_ready: got %b expected 11", {ur_2, rxr_2});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({txv_2, db_2} !== 78'd0)
        $display("FAIL midrst_leftover%0d: got %h expected 0", i, {txv_2, db_2});
      else n_pass++;
      step(); settle();
    end
  endtask

  task automatic test_passthrough_r1();
    do_reset(1'b0);
    drive(8'h61);
    rx_word  = {231'd0, mk(8'h70)};
    rx_valid = 1'b1;
    step(); u_valid = 1'b0; rx_valid = 1'b0; settle();
    n_total++;
    if ({txv_1, txd_1} !== {1'b1, mk(8'h61)})
      $display("FAIL r1_tx: got %h expected %h", {txv_1, txd_1}, {1'b1, mk(8'h61)});
    else n_pass++;
    n_total++;
    if (db_1 !== mk(8'h70)) $display("FAIL r1_rx: got %h expected %h", db_1, mk(8'h70));
    else n_pass++;
    step(); settle();
    n_total++;
    if ({txv_1, db_1} !== 78'd0) $display("FAIL r1_idle: got %h expected 0", {txv_1, db_1});
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; gen2 = 1'b1; idle_inputs();
    test_reset();
    test_pack_r2_gen2();
    test_single_beat_r2();
    test_stall_r4();
    test_back_to_back_rx_r2();
    test_mode_switch_r2();
    test_reset_mid_r2();
    test_passthrough_r1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lpif_txrx_asym_gearbox_slave_name.md
LPIF_TXRX_ASYM_GEARBOX_SLAVE_NAME -- requirements
Module: lpif_txrx_asym_gearbox_slave_name

Interface
REQ-001 Parameter DATA_W, default 64: LPIF data width per beat.
REQ-002 Parameter CRC_W, default 4: LPIF CRC width per beat.
REQ-003 Parameter RATIO, default 2, legal values 1, 2 and 4: maximum beats per FIFO word.
REQ-004 Derived constant BEAT_W = DATA_W+CRC_W+9, which is 77 at defaults; derived constant WORD_W = RATIO*BEAT_W.
REQ-005 Port clk_wr, input, 1 bit: the single clock; one clock, reset is synchronous and active-high.
REQ-006 Port rst_wr, input, 1 bit: synchronous active-high reset.
REQ-007 Port m_gen2_mode, input, 1 bit: 1 sets R_eff = RATIO; 0 sets R_eff = max(RATIO/2, 1).
REQ-008 Ports ustrm_state[3:0], ustrm_protid[1:0], ustrm_data[DATA_W-1:0], ustrm_dvalid, ustrm_crc[CRC_W-1:0], ustrm_crc_valid, ustrm_valid: inputs, one upstream LPIF beat.
REQ-009 Port ustrm_ready, output, 1 bit: the upstream beat is accepted when ustrm_valid & ustrm_ready.
REQ-010 Ports txfifo_upstream_data[WORD_W-1:0], output, and txfifo_upstream_valid, output, plus txfifo_upstream_ready, input: packed word toward the TX FIFO.
REQ-011 Ports rxfifo_downstream_data[WORD_W-1:0], input, rxfifo_downstream_valid, input, and rxfifo_downstream_ready, output: packed word from the RX FIFO.
REQ-012 Ports dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid: outputs, widths as in REQ-008, one downstream beat per cycle.
REQ-013 Port mode_busy, output, 1 bit: high while either gearbox holds a partial or pending word.

Function
REQ-014 Beat layout, LSB first: state[0+:4], protid[4+:2], data[6+:DATA_W], dvalid, crc[CRC_W], crc_valid, valid; slot k occupies word bits [k*BEAT_W +: BEAT_W].
REQ-015 TX: the k-th accepted beat of a word is written to slot k; slot counter tx_cnt counts 0..R_eff-1 and wraps to 0.
REQ-016 TX: on acceptance of beat R_eff-1, txfifo_upstream_valid rises the next cycle; packing latency is 1 cycle after the last beat.
REQ-017 TX: slots at index R_eff and above are driven to zero.
REQ-018 TX: txfifo_upstream_data and txfifo_upstream_valid hold stable until txfifo_upstream_ready is sampled high.
REQ-019 TX: ustrm_ready = ~txfifo_upstream_valid | txfifo_upstream_ready, so a new beat may be accepted into slot 0 in the same cycle the pending word drains.
REQ-020 RX: rxfifo_downstream_ready = ~rx_active | (rx_cnt == R_eff-1).
REQ-021 RX: a word is captured when rxfifo_downstream_valid & rxfifo_downstream_ready; beats are emitted on the following cycles, slot 0 first, one per cycle, with no gaps while words remain available.
REQ-022 RX: dstrm_* outputs are registered; every output is zero in any cycle with no beat being emitted.
REQ-023 RX: the downstream side has no backpressure; back-to-back words stream continuously.
REQ-024 RX state machine: IDLE→STREAM on capture; STREAM holds while rx_cnt < R_eff-1 or a new word is captured; STREAM→IDLE after the last beat when no word is captured.
REQ-025 Mode: R_eff is registered from m_gen2_mode only in cycles where mode_busy = 0.
REQ-026 Mode: a change of m_gen2_mode while busy takes effect at the first idle cycle; the word in flight completes with the old R_eff.
REQ-027 RATIO=1: both gearboxes degenerate to single-register pass-through with 1-cycle latency, and m_gen2_mode has no effect.

Reset
REQ-028 While rst_wr is high at a clock edge, the block clears tx_cnt, rx_cnt and all slot registers, sets txfifo_upstream_valid=0, rxfifo_downstream_ready=0, ustrm_ready=0, all dstrm_*=0, mode_busy=0, RX state to IDLE, and loads R_eff from m_gen2_mode.
REQ-029 A reset asserted mid-word discards the partial TX word and any unemitted RX beats; none of them appears after reset.
REQ-030 ustrm_ready and rxfifo_downstream_ready rise in the first cycle after rst_wr deasserts.

Structure
REQ-031 Package lpif_asym_pkg holds the beat struct typedef, the field offset constants, the BEAT_W function of DATA_W/CRC_W, and the legal RATIO check.
REQ-032 A single sub-module, lpif_asym_gearbox_lane, is instantiated twice: once in pack mode for TX and once in unpack mode for RX.
REQ-033 An illegal RATIO value shall be rejected at elaboration.

Verification
REQ-034 RATIO=2, gen2=1: 4 back-to-back beats with data=1..4 → two words, slots {1,2} then {3,4}; each word valid 1 cycle after its 2nd beat.
REQ-035 RATIO=2, gen2=0: beat data=0xA5 → word with slot0 data=0xA5 and slot1 all zero; 3 RX words → 3 consecutive dstrm beats.
REQ-036 RATIO=4, gen2=1: txfifo_upstream_ready held low 5 cycles → word stable for the whole stall, ustrm_ready=0, no beat lost; the release cycle also accepts a new beat into slot 0.
REQ-037 RX with 2 words valid continuously at RATIO=2 → 4 dstrm beats on consecutive cycles, and rxfifo_downstream_ready high on each last-beat cycle.
REQ-038 m_gen2_mode toggled 1→0 after the 1st of 2 TX beats → the current word completes as a 2-beat word, and the next word is 1-beat.
REQ-039 rst_wr pulsed after 1 of 2 TX beats and mid RX stream → no txfifo_upstream_valid, all dstrm_*=0, and ready signals high 1 cycle after release.
